// File: rtl/binary_mul_dot_acc.sv
// Dot-product accumulator behind a pipelined signed multiplier, with a 2-entry result FIFO.
// Define ACC_SAT_EN to make every add saturate and report a sticky per-vector out_sat flag.
module binary_mul_dot_acc #(
    parameter int P_W     = 25,
    parameter int LATENCY = 14,
    parameter int ACC_W   = 32,
    parameter int LEN     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic signed [P_W-1:0]   P,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_trunc,
    output logic                    out_sat
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

`ifdef ACC_SAT_EN
    // Returns {overflow, clamped_sum}.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] wide;
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sat_add = {1'b1, wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
        end else begin
            sat_add = {1'b0, wide[ACC_W-1:0]};
        end
    endfunction

    logic sat_r;
    logic sat_hit_s;
`endif

    // Stage 0 is captured with the multiplier operands; stage LATENCY lines up with P.
    logic [LATENCY:0]        pipe_v_r;
    logic [LATENCY:0]        pipe_last_r;
    logic [CNT_W-1:0]        in_cnt_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [0:0]              state_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [1:0]              inflight_r;
    logic [1:0]              occ_r;
    logic [1:0]              inflight_nxt_s;
    logic [1:0]              occ_nxt_s;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic signed [ACC_W-1:0] fifo_data_r [2];
    logic [1:0]              fifo_trunc_r;
    logic [1:0]              fifo_sat_r;
    logic                    wr_ptr_r;
    logic                    rd_ptr_r;

    logic                    accept_s;
    logic                    close_in_s;
    logic                    arrive_s;
    logic                    close_out_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    vec_sat_s;
    logic signed [ACC_W-1:0] p_ext_s;
    logic signed [ACC_W-1:0] base_s;
    logic signed [ACC_W-1:0] sum_s;

    assign accept_s    = en && in_valid && in_ready_r;
    assign close_in_s  = in_last || (in_cnt_r == LAST_TERM);
    assign arrive_s    = en && pipe_v_r[LATENCY];
    assign close_out_s = pipe_last_r[LATENCY] || (cnt_r == LAST_TERM);
    assign push_s      = arrive_s && close_out_s;
    assign pop_s       = out_valid_r && out_ready;
    assign p_ext_s     = ACC_W'(P);

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = fifo_data_r[rd_ptr_r];
    assign out_trunc = fifo_trunc_r[rd_ptr_r];
    assign out_sat   = fifo_sat_r[rd_ptr_r];

    // Running sum for the arriving product; IDLE starts a fresh vector from zero.
    always_comb begin
        if (state_r == ST_IDLE) begin
            base_s = {ACC_W{1'b0}};
        end else begin
            base_s = acc_r;
        end
`ifdef ACC_SAT_EN
        {sat_hit_s, sum_s} = sat_add(base_s, p_ext_s);
        vec_sat_s = sat_r || sat_hit_s;
`else
        sum_s     = base_s + p_ext_s;
        vec_sat_s = 1'b0;
`endif
    end

    // Next values of close credits in flight and FIFO occupancy.
    always_comb begin
        inflight_nxt_s = inflight_r;
        occ_nxt_s      = occ_r;
        if ((accept_s && close_in_s) && !push_s) begin
            inflight_nxt_s = inflight_r + 2'd1;
        end else if (!(accept_s && close_in_s) && push_s) begin
            inflight_nxt_s = inflight_r - 2'd1;
        end else begin
            inflight_nxt_s = inflight_r;
        end
        if (push_s && !pop_s) begin
            occ_nxt_s = occ_r + 2'd1;
        end else if (!push_s && pop_s) begin
            occ_nxt_s = occ_r - 2'd1;
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // Valid/last shift pipe, frozen while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_r    <= {(LATENCY+1){1'b0}};
            pipe_last_r <= {(LATENCY+1){1'b0}};
        end else if (en) begin
            pipe_v_r    <= {pipe_v_r[LATENCY-1:0], accept_s};
            pipe_last_r <= {pipe_last_r[LATENCY-1:0], in_last && accept_s};
        end
    end

    // Term counter on the acceptance side, used to reserve a credit for forced closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            in_cnt_r <= close_in_s ? CNT_ZERO : in_cnt_r + CNT_ONE;
        end
    end

    // Accumulator FSM driven by product arrivals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else if (arrive_s) begin
            if (close_out_s) begin
                state_r <= ST_IDLE;
                acc_r   <= {ACC_W{1'b0}};
                cnt_r   <= CNT_ZERO;
            end else begin
                state_r <= ST_ACCUM;
                acc_r   <= sum_s;
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end
    end

`ifdef ACC_SAT_EN
    // Sticky saturation flag for the vector being accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= 1'b0;
        end else if (arrive_s) begin
            sat_r <= close_out_s ? 1'b0 : vec_sat_s;
        end
    end
`endif

    // Two-entry result FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_r[0] <= {ACC_W{1'b0}};
            fifo_data_r[1] <= {ACC_W{1'b0}};
            fifo_trunc_r   <= 2'b00;
            fifo_sat_r     <= 2'b00;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r]  <= sum_s;
                fifo_trunc_r[wr_ptr_r] <= !pipe_last_r[LATENCY];
                fifo_sat_r[wr_ptr_r]   <= vec_sat_s;
                wr_ptr_r               <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Credit counters and the registered handshake flags derived from them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r  <= 2'd0;
            occ_r       <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            inflight_r  <= inflight_nxt_s;
            occ_r       <= occ_nxt_s;
            in_ready_r  <= ({1'b0, inflight_nxt_s} + {1'b0, occ_nxt_s}) < 3'd2;
            out_valid_r <= (occ_nxt_s != 2'd0);
        end
    end

endmodule

// File: tb/tb_binary_mul_dot_acc.sv
// Directed bench for binary_mul_dot_acc with a behavioural multiplier delay line feeding P.
module tb_binary_mul_dot_acc;
    localparam int LATENCY = 14;
    // (-4096)*(-4096) = 2^24 needs a 26-bit signed product to be carried exactly.
    localparam int TB_PW = 26;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic signed [TB_PW-1:0] a_op = 26'sd0;
    logic signed [TB_PW-1:0] b_op = 26'sd0;
    logic signed [TB_PW-1:0] mpipe [0:LATENCY];
    logic signed [TB_PW-1:0] P;

    logic in_ready, out_valid, out_trunc, out_sat;
    logic signed [31:0] out_data;
    logic in_ready26, out_valid26, out_trunc26, out_sat26;
    logic signed [25:0] out_data26;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    assign P = mpipe[LATENCY];

    binary_mul_dot_acc #(.P_W(TB_PW), .LATENCY(LATENCY), .ACC_W(32), .LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .P(P), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_trunc(out_trunc), .out_sat(out_sat));

    binary_mul_dot_acc #(.P_W(TB_PW), .LATENCY(LATENCY), .ACC_W(26), .LEN(16)) dut26 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready26), .P(P), .out_valid(out_valid26), .out_ready(out_ready),
        .out_data(out_data26), .out_trunc(out_trunc26), .out_sat(out_sat26));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: product of the operands sampled at edge t is on P after edge t+LATENCY.
    always @(posedge clk) begin
        if (en) begin
            mpipe[0] <= a_op * b_op;
            for (int k = 1; k <= LATENCY; k++) mpipe[k] <= mpipe[k-1];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one beat and returns the edge count at which it was accepted (-1 on timeout).
    task automatic send(input int a, input int b, input bit last, output int acc_cyc);
        a_op = TB_PW'(a);
        b_op = TB_PW'(b);
        in_last = last;
        in_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            if (en && in_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_valid(output int vcyc);
        vcyc = -1;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                vcyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        tick(2);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'sd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL reset_out_trunc: got %b want 0", out_trunc); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_dot4;
        int t, v;
        out_ready = 1'b1;
        send(3, 4, 1'b0, t);
        send(-5, 6, 1'b0, t);
        send(4095, 4095, 1'b0, t);
        send(-4096, -4096, 1'b1, t);
        wait_valid(v);
        checks++; if (v !== t + LATENCY + 1) begin errors++; $display("FAIL dot4_latency: got %0d want %0d", v, t + LATENCY + 1); end
        checks++; if (out_data !== 32'sd33546223) begin errors++; $display("FAIL dot4_data: got %0d want 33546223", out_data); end
        checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL dot4_trunc: got %b want 0", out_trunc); end
        tick(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dot4_single_result: got %b want 0", out_valid); end
    endtask

    task automatic test_single;
        int t, v;
        send(-4096, 4095, 1'b1, t);
        wait_valid(v);
        checks++; if (out_data !== -32'sd16773120) begin errors++; $display("FAIL single_data: got %0d want -16773120", out_data); end
        checks++; if (v !== t + LATENCY + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", v, t + LATENCY + 1); end
        tick(2);
    endtask

    task automatic test_back_to_back;
        int t1, t2, t3;
        out_ready = 1'b0;
        send(1, 1, 1'b1, t1);
        send(2, 2, 1'b1, t2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", in_ready); end
        tick(LATENCY + 1);
        checks++; if (out_data !== 32'sd1) begin errors++; $display("FAIL b2b_head1: got %0d want 1", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_fifo_full: got %b want 0", in_ready); end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        checks++; if (out_data !== 32'sd4) begin errors++; $display("FAIL b2b_head2: got %0d want 4", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %b want 1", in_ready); end
        send(3, 3, 1'b1, t3);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_third: got %b want 0", in_ready); end
        tick(LATENCY + 1);
        checks++; if (out_data !== 32'sd4) begin errors++; $display("FAIL b2b_head_hold: got %0d want 4", out_data); end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        checks++; if (out_data !== 32'sd9) begin errors++; $display("FAIL b2b_head3: got %0d want 9", out_data); end
        out_ready = 1'b1;
        tick(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_en_stall;
        int t0, t, v;
        out_ready = 1'b1;
        send(10, 10, 1'b0, t0);
        send(10, 10, 1'b0, t);
        en = 1'b0;
        a_op = 26'sd10;
        b_op = 26'sd10;
        in_valid = 1'b1;
        tick(5);
        en = 1'b1;
        send(10, 10, 1'b0, t);
        send(10, 10, 1'b1, t);
        checks++; if (t !== t0 + 8) begin errors++; $display("FAIL stall_accept: got %0d want %0d", t, t0 + 8); end
        wait_valid(v);
        checks++; if (v !== t0 + 3 + LATENCY + 1 + 5) begin errors++; $display("FAIL stall_latency: got %0d want %0d", v, t0 + 3 + LATENCY + 1 + 5); end
        checks++; if (out_data !== 32'sd400) begin errors++; $display("FAIL stall_data: got %0d want 400", out_data); end
        tick(2);
    endtask

    task automatic test_trunc;
        int t;
        out_ready = 1'b0;
        for (int i = 1; i <= 17; i++) send(1, 1, (i == 17), t);
        tick(LATENCY + 1);
        checks++; if (out_data !== 32'sd16) begin errors++; $display("FAIL trunc_data1: got %0d want 16", out_data); end
        checks++; if (out_trunc !== 1'b1) begin errors++; $display("FAIL trunc_flag1: got %b want 1", out_trunc); end
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        checks++; if (out_data !== 32'sd1) begin errors++; $display("FAIL trunc_data2: got %0d want 1", out_data); end
        checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL trunc_flag2: got %b want 0", out_trunc); end
        out_ready = 1'b1;
        tick(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL trunc_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_saturation;
        int t;
        logic signed [25:0] exp26;
        logic exp_sat26;
`ifdef ACC_SAT_EN
        exp26 = 26'sd33554431;
        exp_sat26 = 1'b1;
`else
        exp26 = 26'sd0;
        exp_sat26 = 1'b0;
`endif
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(-4096, -4096, (i == 4), t);
        tick(LATENCY + 1);
        checks++; if (out_data26 !== exp26) begin errors++; $display("FAIL sat26_data: got %0d want %0d", out_data26, exp26); end
        checks++; if (out_sat26 !== exp_sat26) begin errors++; $display("FAIL sat26_flag: got %b want %b", out_sat26, exp_sat26); end
        checks++; if (out_data !== 32'sd67108864) begin errors++; $display("FAIL sat32_data: got %0d want 67108864", out_data); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL sat32_flag: got %b want 0", out_sat); end
        out_ready = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid;
        int t, v;
        out_ready = 1'b0;
        send(7, 7, 1'b0, t);
        send(7, 7, 1'b0, t);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        send(5, 5, 1'b1, t);
        wait_valid(v);
        checks++; if (out_data !== 32'sd25) begin errors++; $display("FAIL rstmid_data: got %0d want 25", out_data); end
        checks++; if (out_trunc !== 1'b0) begin errors++; $display("FAIL rstmid_trunc: got %b want 0", out_trunc); end
        out_ready = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset;
        test_dot4;
        test_single;
        test_back_to_back;
        test_en_stall;
        test_trunc;
        test_saturation;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
